// File: rtl/register_writeback_if.sv
// register_writeback_if: execute, load-data, register-file write and forwarding signals of the writeback stage
interface register_writeback_if;
  logic        stall;
  logic        cpu_stat_wb;
  logic [4:0]  rd_adr_ex;
  logic        wbk_rd_reg_ex;
  logic        is_load_ex;
  logic [2:0]  ld_funct3_ex;
  logic [1:0]  ld_ofs_ex;
  logic [31:0] alu_data_ex;
  logic        ld_data_vld;
  logic [31:0] ld_rdata;
  logic        wb_run;
  logic        wb_err;
  logic [4:0]  rd_adr_wb;
  logic        wbk_rd_reg_wb;
  logic [31:0] wbk_data_wb;
  logic        fwd_vld;
  logic [4:0]  fwd_adr;
  logic [31:0] fwd_data;
  modport master (
    output stall, cpu_stat_wb, rd_adr_ex, wbk_rd_reg_ex, is_load_ex, ld_funct3_ex, ld_ofs_ex, alu_data_ex,
    output ld_data_vld, ld_rdata,
    input  wb_run, wb_err, rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb, fwd_vld, fwd_adr, fwd_data
  );
  modport slave (
    input  stall, cpu_stat_wb, rd_adr_ex, wbk_rd_reg_ex, is_load_ex, ld_funct3_ex, ld_ofs_ex, alu_data_ex,
    input  ld_data_vld, ld_rdata,
    output wb_run, wb_err, rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb, fwd_vld, fwd_adr, fwd_data
  );
endinterface

// File: rtl/register_writeback.sv
// register_writeback: writeback stage with load alignment and register-file write port
// Define WBK_FWD_EN to build the one-cycle-delayed forwarding copy of each committed write.
module register_writeback (
  input  logic           clk,
  input  logic           rst_n,
  register_writeback_if.slave bus
);
  typedef enum logic [1:0] {WB_IDLE, WB_LDW, WB_WRT} wb_state_e;
  wb_state_e   state;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  ofs_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_algn;
  logic        ld_err;
  logic        wr_alu;
  logic        wr_ld;
  always_comb begin
    ld_byte = bus.ld_rdata[{ofs_q, 3'b000} +: 8];
    ld_half = bus.ld_rdata[{ofs_q[1], 4'b0000} +: 16];
    ld_algn = f3_q == 3'b000 ? {{24{ld_byte[7]}}, ld_byte} :
              f3_q == 3'b001 ? {{16{ld_half[15]}}, ld_half} :
              f3_q == 3'b100 ? {24'b0, ld_byte} :
              f3_q == 3'b101 ? {16'b0, ld_half} : bus.ld_rdata;
    ld_err  = f3_q == 3'b011 || f3_q[2:1] == 2'b11 || (f3_q[1:0] == 2'b01 && ofs_q[0]) ||
              (f3_q == 3'b010 && ofs_q != 2'b00);
    wr_alu  = bus.wbk_rd_reg_ex && bus.rd_adr_ex != 5'd0;
    wr_ld   = we_q && rd_q != 5'd0 && !ld_err;
  end
  assign bus.wb_run = state != WB_IDLE;
  // Write-port outputs are loaded on the edge entering WB_WRT so they are valid during that cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state             <= WB_IDLE;
      rd_q              <= '0;
      we_q              <= 1'b0;
      f3_q              <= '0;
      ofs_q             <= '0;
      bus.wbk_rd_reg_wb <= 1'b0;
      bus.wb_err        <= 1'b0;
      bus.rd_adr_wb     <= '0;
      bus.wbk_data_wb   <= '0;
    end else begin
      bus.wbk_rd_reg_wb <= 1'b0;
      bus.wb_err        <= 1'b0;
      if (state == WB_IDLE && bus.cpu_stat_wb && !bus.stall) begin
        rd_q  <= bus.rd_adr_ex;
        we_q  <= bus.wbk_rd_reg_ex;
        f3_q  <= bus.ld_funct3_ex;
        ofs_q <= bus.ld_ofs_ex;
        state <= bus.is_load_ex ? WB_LDW : WB_WRT;
        if (!bus.is_load_ex && wr_alu) begin
          bus.wbk_rd_reg_wb <= 1'b1;
          bus.rd_adr_wb     <= bus.rd_adr_ex;
          bus.wbk_data_wb   <= bus.alu_data_ex;
        end
      end else if (state == WB_LDW) begin
        if (bus.stall) state <= WB_IDLE;
        else if (bus.ld_data_vld) begin
          state      <= WB_WRT;
          bus.wb_err <= ld_err;
          if (wr_ld) begin
            bus.wbk_rd_reg_wb <= 1'b1;
            bus.rd_adr_wb     <= rd_q;
            bus.wbk_data_wb   <= ld_algn;
          end
        end
      end else if (state == WB_WRT) state <= WB_IDLE;
    end
`ifdef WBK_FWD_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.fwd_vld  <= 1'b0;
      bus.fwd_adr  <= '0;
      bus.fwd_data <= '0;
    end else begin
      bus.fwd_vld  <= bus.wbk_rd_reg_wb;
      bus.fwd_adr  <= bus.wbk_rd_reg_wb ? bus.rd_adr_wb : 5'd0;
      bus.fwd_data <= bus.wbk_rd_reg_wb ? bus.wbk_data_wb : 32'd0;
    end
`else
  assign bus.fwd_vld  = 1'b0;
  assign bus.fwd_adr  = '0;
  assign bus.fwd_data = '0;
`endif
endmodule

// File: doc/register_writeback.md
REGISTER_WRITEBACK -- requirements
Module: register_writeback

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 SHALL have ports: stall input 1, pipeline stall/flush; cpu_stat_wb input 1, writeback request from execute.
REQ-003 SHALL have ports: rd_adr_ex input 5, destination register; wbk_rd_reg_ex input 1, instruction writes rd; is_load_ex input 1, result comes from memory.
REQ-004 SHALL have ports: ld_funct3_ex input 3, load type; ld_ofs_ex input 2, byte offset of load address; alu_data_ex input 32, non-load result.
REQ-005 SHALL have ports: ld_data_vld input 1, memory read data valid; ld_rdata input 32, raw memory word.
REQ-006 SHALL have ports: wb_run output 1, busy; wb_err output 1, illegal/misaligned load pulse.
REQ-007 SHALL have ports: rd_adr_wb output 5, wbk_rd_reg_wb output 1, and wbk_data_wb output 32, forming the register-file write port.
REQ-008 SHALL have ports: fwd_vld output 1, fwd_adr output 5, and fwd_data output 32, forming the forwarding port (see Configuration).

Function
REQ-009 SHALL implement states WB_IDLE, WB_LDW (wait load data) and WB_WRT (write cycle); wb_run SHALL be 1 in any state other than WB_IDLE.
REQ-010 In WB_IDLE with cpu_stat_wb=1 and stall=0 (accept), SHALL capture rd_adr_ex, wbk_rd_reg_ex, ld_funct3_ex, ld_ofs_ex and alu_data_ex, then go to WB_LDW if is_load_ex=1, else to WB_WRT.
REQ-011 SHALL ignore cpu_stat_wb while not in WB_IDLE.
REQ-012 In WB_LDW: stall=1 SHALL return to WB_IDLE with no write; ld_data_vld=1 SHALL capture aligned data and go to WB_WRT; otherwise SHALL remain in WB_LDW.
REQ-013 WB_WRT SHALL last exactly one cycle, always go to WB_IDLE, and complete regardless of stall.
REQ-014 In WB_WRT, wbk_rd_reg_wb SHALL be 1 only if the captured write-enable is 1, the captured rd is nonzero, and no error is pending; it SHALL be 0 in every other state.
REQ-015 Latency: non-load accepted in cycle N -> write in cycle N+1; load with ld_data_vld in cycle M -> write in cycle M+1.
REQ-016 Load alignment, byte = ld_rdata[8*ofs+7:8*ofs], half = ld_rdata[16*ofs[1]+15:16*ofs[1]]: LB(000) sign-extends byte; LH(001) sign-extends half; LW(010) passes the word; LBU(100) zero-extends byte; LHU(101) zero-extends half.
REQ-017 funct3 011/110/111, LH/LHU with ofs[0]=1, or LW with ofs!=0 SHALL suppress the write and pulse wb_err for one cycle during WB_WRT.
REQ-018 rd_adr_wb and wbk_data_wb SHALL be registered and SHALL hold their last values when no write is issued.

Reset
REQ-019 rst_n=0 SHALL force WB_IDLE and all outputs and captured fields to 0, including mid-operation, with no write issued.

Configuration
REQ-020 With WBK_FWD_EN defined, fwd_vld/fwd_adr/fwd_data SHALL repeat the committed write (wbk_rd_reg_wb, rd_adr_wb, wbk_data_wb) one cycle later, for a single cycle, to cover read-after-write in the read sequencer.
REQ-021 Without WBK_FWD_EN, fwd_vld, fwd_adr and fwd_data SHALL be constant 0 and no forwarding registers SHALL be built.

Verification
REQ-022 ALU write: accept rd=5, data=0x12345678 -> next cycle wbk_rd_reg_wb=1, rd_adr_wb=5, wbk_data_wb=0x12345678; wb_run=1 for 1 cycle.
REQ-023 x0 write: accept rd=0, data=0xFFFFFFFF -> wbk_rd_reg_wb stays 0 in all cycles; wb_run pulses for 1 cycle.
REQ-024 Load LB ofs=3 with ld_rdata=0x80AABBCC delivered 3 cycles after accept -> wb_run high 4 cycles, then write data 0xFFFFFF80.
REQ-025 LHU ofs=2 with ld_rdata=0x8001_1234 -> 0x00008001; LH ofs=1 -> no write, wb_err=1 for 1 cycle.
REQ-026 Stall in WB_LDW, or rst_n=0 in WB_LDW -> WB_IDLE, no write; a later ld_data_vld is ignored.
REQ-027 With WBK_FWD_EN: write rd=7, data=0xA5 -> fwd_vld=1, fwd_adr=7, fwd_data=0xA5 in the following cycle only; without the macro fwd_* stay 0.
